// File: rtl/link_rx_fifo.sv
// Receive-side flit buffer behind the link delay stage.
// The delay stage cannot be stalled, so flits that arrive while the queue is
// full are dropped, and the drops are recorded (sticky flag + saturating count).
// Flits leave through a first-word fall-through valid/ready port.
module link_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_ack,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // Handshake decode; a full queue still accepts a flit when the head leaves in the same cycle.
    always_comb begin
        pop     = out_valid & out_ready;
        push_ok = in_ack & ((level < FULL) | pop);
        drop    = in_ack & ~push_ok;
    end

    // Flit storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Drop bookkeeping: sticky flag plus a counter that holds at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Head-of-queue outputs, driven from registers only; zero while empty.
    always_comb begin
        out_valid = (level != '0);
        out_data  = out_valid ? mem[rp] : '0;
    end

endmodule

// File: tb/tb_link_rx_fifo.sv
// Self-checking bench for link_rx_fifo: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_link_rx_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents, the drop flag and the drop count.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;
    int                m_drop;
    // Flits seen leaving the DUT and flits the model says should leave.
    logic [DATA_W-1:0] dut_rx[$];
    logic [DATA_W-1:0] exp_rx[$];
    int                cyc = 0;

    link_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model, then wait past the edge.
    task automatic drive(input bit ack, input logic [DATA_W-1:0] d, input bit rdy, input bit rst);
        bit popped;
        in_ack    = ack;
        in_data   = d;
        out_ready = rdy;
        reset     = rst;
        if (!rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (out_valid && rdy) dut_rx.push_back(out_data);
            popped = (mq.size() != 0) && rdy;
            if (popped) exp_rx.push_back(mq.pop_front());
            if (ack) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        in_ack = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0);
        drive(0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", out_data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %h want 00", drop_cnt); end
        drive(0, '0, 0, 1);
    endtask

    task automatic test_single();
        drive(1, 16'hA5A5, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h want a5a5", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
        drive(0, '0, 0, 1);
        checks++; if (out_data !== 16'hA5A5) begin errors++; $display("FAIL single_hold got %h want a5a5", out_data); end
        drive(0, '0, 1, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL single_pop_data got %h want 0000", out_data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level got %0d want 0", level); end
    endtask

    task automatic test_fill_overflow();
        drive(0, '0, 0, 0);
        for (int i = 1; i <= 5; i++) drive(1, 16'(i), 0, 1);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_data !== 16'(k + 1)) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", k, out_data, 16'(k + 1)); end
            drive(0, '0, 1, 1);
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_empty got %0d want 0", level); end
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_sticky got %b/%0d want 1/1", overflow, drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        drive(0, '0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 16'h0010 + 16'(i), 0, 1);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_full got %0d want 4", level); end
        drive(1, 16'h0014, 1, 1);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d want 4", level); end
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_drop got %b/%0d want 0/0", overflow, drop_cnt); end
        checks++; if (out_data !== 16'h0011) begin errors++; $display("FAIL fpp_head got %h want 0011", out_data); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_data !== 16'h0011 + 16'(k)) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", k, out_data, 16'h0011 + 16'(k)); end
            drive(0, '0, 1, 1);
        end
    endtask

    task automatic test_wrap();
        int n;
        drive(0, '0, 0, 0);
        dut_rx.delete();
        exp_rx.delete();
        n = 0;
        for (int t = 0; t < 10 * 37 + 40; t++) begin
            bit ack;
            ack = (t % 37 == 0) && (n < 10);
            drive(ack, 16'h0100 + 16'(n), (t % 4) == 3, 1);
            if (ack) n++;
        end
        checks++; if (dut_rx.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", dut_rx.size()); end
        for (int i = 0; i < 10 && i < dut_rx.size(); i++) begin
            checks++;
            if (dut_rx[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL wrap_order%0d got %h want %h", i, dut_rx[i], 16'h0100 + 16'(i)); end
        end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL wrap_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_saturation();
        drive(0, '0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 16'h0200 + 16'(i), 0, 1);
        for (int i = 1; i <= 300; i++) begin
            drive(1, 16'($urandom), 0, 1);
            if (i == 255) begin
                checks++;
                if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255 got %h want ff", drop_cnt); end
            end
        end
        checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_300 got %h want ff", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", overflow); end
        checks++; if (level !== 3'd4 || out_data !== 16'h0200) begin errors++; $display("FAIL sat_head got %0d/%h want 4/0200", level, out_data); end
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 16'h0300 + 16'(i), 0, 1);
        drive(0, '0, 1, 1);
        checks++; if (level !== 3'd3 || drop_cnt !== 8'd1) begin errors++; $display("FAIL rmid_pre got %0d/%0d want 3/1", level, drop_cnt); end
        drive(1, 16'hBEEF, 1, 0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL rmid_out got %b/%h want 0/0000", out_valid, out_data); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop got %b/%0d want 0/0", overflow, drop_cnt); end
        drive(0, '0, 1, 1);
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %0d/%b want 0/0", level, out_valid); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] want_data;
        drive(0, '0, 0, 0);
        dut_rx.delete();
        exp_rx.delete();
        for (int t = 0; t < 3000; t++) begin
            drive($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
            want_data = (mq.size() != 0) ? mq[0] : '0;
            checks++;
            if (level !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || out_data !== want_data) begin
                errors++;
                $display("FAIL rand_q t=%0d got lvl=%0d v=%b d=%h want lvl=%0d v=%b d=%h",
                         t, level, out_valid, out_data, mq.size(), mq.size() != 0, want_data);
            end
            checks++;
            if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL rand_drop t=%0d got %b/%0d want %b/%0d", t, overflow, drop_cnt, m_ovf, m_drop);
            end
        end
        checks++;
        if (dut_rx.size() != exp_rx.size()) begin errors++; $display("FAIL rand_rx_count got %0d want %0d", dut_rx.size(), exp_rx.size()); end
        for (int i = 0; i < dut_rx.size() && i < exp_rx.size(); i++) begin
            checks++;
            if (dut_rx[i] !== exp_rx[i]) begin errors++; $display("FAIL rand_rx%0d got %h want %h", i, dut_rx[i], exp_rx[i]); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_ack    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_rx_fifo.md
# link_rx_fifo

Receive-side buffer sitting directly downstream of the 36-cycle link delay stage in the custom NoC. It captures each 16-bit flit presented with the delay stage's single-cycle `ack` strobe, which carries no backpressure. It queues the flits in a small circular FIFO and forwards them to the router input port with a valid/ready handshake. Because the delay stage cannot be stalled, the block also detects and counts flits lost to overflow.

## Interface
- `DATA_W`, 16: flit width; must match the delay stage output.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8: width of the saturating drop counter.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low.
- `in_data`  in  DATA_W  flit from the delay stage; sampled only when `in_ack`=1.
- `in_ack`  in  1  one-cycle write strobe from the delay stage.
- `out_data`  out  DATA_W  head-of-queue flit; 0 when empty.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  router accepts the head flit this cycle.
- `level`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set on the first dropped flit.
- `drop_cnt`  out  CNT_W  number of dropped flits; saturates at all-ones.

## Operation
- Storage: `DEPTH` x `DATA_W` register array, with write pointer `wp` and read pointer `rp`.
  - Each pointer is log2(DEPTH) bits and wraps modulo DEPTH.
  - Occupancy is held in `level`.
- Reset (`reset`=0 at a clock edge):
  - `wp`, `rp` and `level` go to 0.
  - `overflow` goes to 0 and `drop_cnt` goes to 0.
  - Array contents are don't-care.
  - Outputs become `out_valid`=0 and `out_data`=0.
  - `in_ack` is ignored while reset is held.
- Pop: `pop` = `out_valid` & `out_ready`. On a pop, `rp` increments.
- Push request: `in_ack`=1. It is accepted when `level` < DEPTH, or when `level` = DEPTH and `pop`=1 in the same cycle.
  - Accepted: `mem[wp]` ← `in_data` and `wp` increments.
  - Rejected: the flit is discarded, `overflow` ← 1, and `drop_cnt` increments unless it is already all-ones.
- `level` update: +1 on an accepted push without a pop; −1 on a pop without a push; unchanged when both or neither occur.
- Outputs:
  - `out_valid` = (`level` ≠ 0).
  - `out_data` = `mem[rp]` when valid, else 0 (first-word fall-through).
- `out_data` must remain stable while `out_valid`=1 and `out_ready`=0.
- `overflow` and `drop_cnt` clear only on reset.

## Timing
- Latency: `in_ack` sampled at edge N on an empty FIFO gives `out_valid`=1 and `out_data`=that flit from edge N onward, i.e. visible in cycle N+1.
- No combinational path from `in_ack`/`in_data` to any output; all outputs are functions of registers only.
- Push and pop on an empty FIFO in the same cycle cannot occur, because `out_valid`=0 forbids the pop. The push proceeds normally.
- Full (`level`=DEPTH) with `in_ack` and `pop` in the same cycle:
  - The head is removed and the new flit is written at `wp`.
  - `level` stays at DEPTH; no drop occurs.
- Full with `in_ack` and no `pop`: a drop occurs at that edge, and `drop_cnt` is visible incremented in the next cycle.
- Wrap-around: after DEPTH pushes, `wp` returns to 0; ordering is preserved across the wrap.
- Reset mid-operation: all queued flits are discarded and the next cycle shows `out_valid`=0 regardless of `out_ready`. A coincident `in_ack` is lost but not counted.
- Upstream strobe cadence is normally 1 per 37 cycles; the block must also handle back-to-back `in_ack` on consecutive cycles.

## Test plan
- Reset then single flit: release reset, pulse `in_ack` with `in_data`=16'hA5A5, hold `out_ready`=0.
  - Next cycle: `out_valid`=1, `out_data`=16'hA5A5, `level`=1.
  - Raise `out_ready` for one cycle: `out_valid`=0, `out_data`=0, `level`=0.
- Fill and overflow: `out_ready`=0, push 16'h0001..16'h0005 back-to-back.
  - Response: `level`=4, `overflow`=1, `drop_cnt`=1.
  - Drain: outputs 0001, 0002, 0003, 0004 in order.
- Full with simultaneous push/pop: fill with 16'h0010..16'h0013, then push 16'h0014 with `out_ready`=1.
  - Response: `level`=4, `drop_cnt`=0, head becomes 0011.
  - Final drain order: 0011, 0012, 0013, 0014.
- Wrap-around: stream 10 flits 16'h0100..16'h0109, one per 37 cycles, with `out_ready` alternating 3 cycles low / 1 cycle high.
  - All 10 flits are received in order; `drop_cnt`=0.
- Saturation: force 300 drops while full with `out_ready`=0.
  - `drop_cnt`=8'hFF and stays there; `overflow`=1.
- Reset mid-operation: with `level`=3, assert `reset`=0 for one cycle together with `in_ack`.
  - Next cycle: `level`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0.
